// File: rtl/patch_streamer.sv
// Raster-to-patch reorderer: buffers one strip of PATCH_SIZE rows, then drains
// that strip patch by patch with patch index, in-patch position and last flags.
module patch_streamer #(
    parameter int CHANNEL_SIZE = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int PIXEL_WIDTH  = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int IMG_WIDTH    = 16,
    parameter int IMG_HEIGHT   = 16,
    parameter int PATCH_SIZE   = 4,
    parameter int PATCH_IDX_W  = 8,
    parameter int POS_IDX_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic [PATCH_IDX_W-1:0] out_patch_idx,
    output logic [POS_IDX_W-1:0]   out_pos_idx,
    output logic                   out_patch_last,
    output logic                   out_frame_last,
    output logic                   frame_done,
    output logic [1:0]             state
);

    localparam int LOG2P  = $clog2(PATCH_SIZE);
    localparam int NCOL   = IMG_WIDTH / PATCH_SIZE;
    localparam int NSTRIP = IMG_HEIGHT / PATCH_SIZE;
    localparam int XW     = $clog2(IMG_WIDTH);
    localparam int CW     = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int SW     = (NSTRIP > 1) ? $clog2(NSTRIP) : 1;

    localparam logic [XW-1:0]          X_LAST   = XW'(IMG_WIDTH - 1);
    localparam logic [LOG2P-1:0]       P_LAST   = LOG2P'(PATCH_SIZE - 1);
    localparam logic [CW-1:0]          COL_LAST = CW'(NCOL - 1);
    localparam logic [SW-1:0]          STR_LAST = SW'(NSTRIP - 1);
    localparam logic [PATCH_IDX_W-1:0] NCOL_IDX = PATCH_IDX_W'(NCOL);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1
    } state_e;

    state_e                 state_q;
    logic [XW-1:0]          x_q;
    logic [LOG2P-1:0]       y_q;
    logic [SW-1:0]          strip_q;
    logic [CW-1:0]          col_q;
    logic [LOG2P-1:0]       r_q;
    logic [LOG2P-1:0]       c_q;
    logic [PATCH_IDX_W-1:0] base_q;
    logic                   frame_done_q;

    logic [PIXEL_WIDTH-1:0] strip_buf [PATCH_SIZE][IMG_WIDTH];

    logic          in_fire;
    logic          out_fire;
    logic [XW-1:0] rd_x_d;
    logic          patch_last_d;

    assign in_fire      = in_valid && (state_q == FILL);
    assign out_fire     = out_ready && (state_q == DRAIN);
    assign rd_x_d       = (XW'(col_q) << LOG2P) | XW'(c_q);
    assign patch_last_d = (r_q == P_LAST) && (c_q == P_LAST);

    always_ff @(posedge clk) begin
        if (in_fire) begin
            strip_buf[y_q][x_q] <= in_pixel;
        end
    end

    // base_q tracks strip*NCOL incrementally so no general multiplier is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            x_q          <= '0;
            y_q          <= '0;
            strip_q      <= '0;
            col_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            base_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (in_fire) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    if (y_q == P_LAST) begin
                        y_q     <= '0;
                        state_q <= DRAIN;
                    end else begin
                        y_q <= y_q + 1'b1;
                    end
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
            if (out_fire) begin
                if (c_q == P_LAST) begin
                    c_q <= '0;
                    if (r_q == P_LAST) begin
                        r_q <= '0;
                        if (col_q == COL_LAST) begin
                            col_q   <= '0;
                            state_q <= FILL;
                            if (strip_q == STR_LAST) begin
                                strip_q      <= '0;
                                base_q       <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                strip_q <= strip_q + 1'b1;
                                base_q  <= base_q + NCOL_IDX;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
        end
    end

    assign in_ready       = (state_q == FILL);
    assign out_valid      = (state_q == DRAIN);
    assign out_pixel      = strip_buf[r_q][rd_x_d];
    assign out_patch_idx  = base_q + PATCH_IDX_W'(col_q);
    assign out_pos_idx    = (POS_IDX_W'(r_q) << LOG2P) | POS_IDX_W'(c_q);
    assign out_patch_last = patch_last_d;
    assign out_frame_last = patch_last_d && (col_q == COL_LAST) && (strip_q == STR_LAST);
    assign frame_done     = frame_done_q;
    assign state          = state_q;

endmodule

// File: tb/tb_patch_streamer.sv
// Scoreboard bench for patch_streamer: default 16x16/P4 instance plus an 8x4/P2
// single-channel instance, both checked against a loop-based reordering model.
module tb_patch_streamer;

    localparam int W   = 16;
    localparam int H   = 16;
    localparam int P   = 4;
    localparam int PW  = 24;
    localparam int W2  = 8;
    localparam int H2  = 4;
    localparam int P2  = 2;
    localparam int PW2 = 8;

    typedef struct {
        logic [31:0] pix;
        int          patch;
        int          pos;
        bit          pl;
        bit          fl;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, in_valid, in_ready, out_valid, out_ready;
    logic [PW-1:0] in_pixel, out_pixel;
    logic [7:0]    out_patch_idx, out_pos_idx;
    logic          out_patch_last, out_frame_last, frame_done;
    logic [1:0]    state;

    logic           reset2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [PW2-1:0] in_pixel2, out_pixel2;
    logic [7:0]     out_patch_idx2, out_pos_idx2;
    logic           out_patch_last2, out_frame_last2, frame_done2;
    logic [1:0]     state2;

    patch_streamer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_patch_idx(out_patch_idx), .out_pos_idx(out_pos_idx),
        .out_patch_last(out_patch_last), .out_frame_last(out_frame_last),
        .frame_done(frame_done), .state(state)
    );

    patch_streamer #(
        .NUM_CHANNELS(1), .IMG_WIDTH(W2), .IMG_HEIGHT(H2), .PATCH_SIZE(P2)
    ) dut2 (
        .clk(clk), .reset(reset2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_pixel(in_pixel2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_pixel(out_pixel2),
        .out_patch_idx(out_patch_idx2), .out_pos_idx(out_pos_idx2),
        .out_patch_last(out_patch_last2), .out_frame_last(out_frame_last2),
        .frame_done(frame_done2), .state(state2)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: walk strips, patch columns, rows, columns and pick img[y*w+x].
    function automatic void model(input int w, input int h, input int p,
                                  input logic [31:0] img[$], output exp_t res[$]);
        exp_t e;
        res = {};
        for (int s = 0; s < h / p; s++)
            for (int col = 0; col < w / p; col++)
                for (int r = 0; r < p; r++)
                    for (int c = 0; c < p; c++) begin
                        e.pix   = img[(s * p + r) * w + col * p + c];
                        e.patch = s * (w / p) + col;
                        e.pos   = r * p + c;
                        e.pl    = (r == p - 1) && (c == p - 1);
                        e.fl    = e.pl && (col == w / p - 1) && (s == h / p - 1);
                        res.push_back(e);
                    end
    endfunction

    exp_t exp_q[$];
    exp_t exp2_q[$];
    int   outs = 0;
    int   done_cnt = 0;
    int   done2_cnt = 0;
    int   stop_target = 32'h7fff_ffff;
    bit   rand_ready = 1'b0;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (outs >= stop_target) out_ready = 1'b0;
            else if (rand_ready)     out_ready = 1'($urandom & 1);
            else                     out_ready = 1'b1;
        end
    end

    bit          held = 1'b0;
    bit          done_due = 1'b0;
    logic [63:0] held_val;
    logic [63:0] cur_val;
    exp_t        me;
    always @(negedge clk) begin
        cur_val = 64'({out_pixel, out_patch_idx, out_pos_idx, out_patch_last, out_frame_last});
        if (reset !== 1'b0) begin
            held     = 1'b0;
            done_due = 1'b0;
        end else begin
            if (done_due) check("frame_done_pulse", 64'(frame_done), 64'd1);
            else if (frame_done === 1'b1) check("frame_done_spurious", 64'(frame_done), 64'd0);
            if (frame_done === 1'b1) done_cnt++;
            done_due = 1'b0;
            if (held && out_valid === 1'b1) check("stall_stable", cur_val, held_val);
            held = 1'b0;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(out_pixel), 64'hdead);
                end else begin
                    me = exp_q.pop_front();
                    check("pixel",      64'(out_pixel),      64'(me.pix));
                    check("patch_idx",  64'(out_patch_idx),  64'(me.patch));
                    check("pos_idx",    64'(out_pos_idx),    64'(me.pos));
                    check("patch_last", 64'(out_patch_last), 64'(me.pl));
                    check("frame_last", 64'(out_frame_last), 64'(me.fl));
                end
                outs++;
                if (out_frame_last === 1'b1) done_due = 1'b1;
            end else if (out_valid === 1'b1) begin
                held     = 1'b1;
                held_val = cur_val;
            end
        end
    end

    exp_t me2;
    always @(negedge clk) begin
        if (reset2 === 1'b0) begin
            if (frame_done2 === 1'b1) done2_cnt++;
            if (out_valid2 === 1'b1 && out_ready2 === 1'b1) begin
                if (exp2_q.size() == 0) begin
                    check("s_unexpected_output", 64'(out_pixel2), 64'hdead);
                end else begin
                    me2 = exp2_q.pop_front();
                    check("s_pixel",      64'(out_pixel2),      64'(me2.pix));
                    check("s_patch_idx",  64'(out_patch_idx2),  64'(me2.patch));
                    check("s_pos_idx",    64'(out_pos_idx2),    64'(me2.pos));
                    check("s_patch_last", 64'(out_patch_last2), 64'(me2.pl));
                    check("s_frame_last", 64'(out_frame_last2), 64'(me2.fl));
                end
            end
        end
    end

    task automatic send_frame(input logic [31:0] img[$], input int count, input bit gaps);
        bit rdy, got;
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            got = 1'b0;
            for (int n = 0; n < 3000 && !got; n++) begin
                @(negedge clk);
                rdy = in_ready;
                in_pixel = rdy ? img[i][PW-1:0] : PW'($urandom);
                @(posedge clk);
                #1;
                got = rdy;
            end
            if (!got) begin
                $display("FAIL in_handshake_timeout: pixel %0d never accepted", i);
                $fatal(1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 20000 && exp_q.size() != 0; n++) @(posedge clk);
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic void rand_img(output logic [31:0] img[$]);
        img = {};
        for (int i = 0; i < W * H; i++) img.push_back($urandom & 32'h00ff_ffff);
    endfunction

    logic [31:0] img_a[$], img_b[$], img_d[$], img_e[$], img_s[$];
    exp_t        tmp[$];
    bit          got2;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pixel = '0;
        reset2 = 1'b1; in_valid2 = 1'b0; in_pixel2 = '0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        reset2 = 1'b0;
        check("reset_state",      64'(state),      64'd0);
        check("reset_out_valid",  64'(out_valid),  64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        check("reset_in_ready",   64'(in_ready),   64'd1);

        // Two back-to-back frames: a ramp with ready held high, then random data and handshakes.
        for (int i = 0; i < W * H; i++) img_a.push_back(32'(i));
        rand_img(img_b);
        model(W, H, P, img_a, tmp);
        foreach (tmp[i]) exp_q.push_back(tmp[i]);
        model(W, H, P, img_b, tmp);
        foreach (tmp[i]) exp_q.push_back(tmp[i]);
        send_frame(img_a, W * H, 1'b0);
        rand_ready = 1'b1;
        send_frame(img_b, W * H, 1'b1);
        wait_drain();

        // Abandon a frame by reset after 7 outputs of strip 1.
        rand_img(img_d);
        model(W, H, P, img_d, tmp);
        for (int i = 0; i < W * P + 7; i++) exp_q.push_back(tmp[i]);
        stop_target = outs + W * P + 7;
        send_frame(img_d, 2 * W * P, 1'b1);
        for (int n = 0; n < 5000 && outs < stop_target; n++) begin @(posedge clk); #2; end
        check("reset_frame_outputs", 64'(outs), 64'(stop_target));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_state",     64'(state),     64'd0);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready",  64'(in_ready),  64'd1);
        check("midreset_leftover",  64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        stop_target = 32'h7fff_ffff;

        rand_img(img_e);
        model(W, H, P, img_e, tmp);
        foreach (tmp[i]) exp_q.push_back(tmp[i]);
        send_frame(img_e, W * H, 1'b1);
        wait_drain();
        check("frame_done_count", 64'(done_cnt), 64'd3);

        // Small geometry instance: 8x4 image, 2x2 patches, one channel.
        for (int i = 0; i < W2 * H2; i++) img_s.push_back(32'(i));
        model(W2, H2, P2, img_s, tmp);
        foreach (tmp[i]) exp2_q.push_back(tmp[i]);
        for (int i = 0; i < W2 * H2; i++) begin
            in_valid2 = 1'b1;
            in_pixel2 = img_s[i][PW2-1:0];
            got2 = 1'b0;
            for (int n = 0; n < 500 && !got2; n++) begin
                @(negedge clk);
                got2 = in_ready2;
                @(posedge clk);
                #1;
            end
            if (!got2) begin
                $display("FAIL s_in_handshake_timeout: pixel %0d never accepted", i);
                $fatal(1);
            end
        end
        in_valid2 = 1'b0;
        for (int n = 0; n < 2000 && exp2_q.size() != 0; n++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("s_drain_remaining",  64'(exp2_q.size()), 64'd0);
        check("s_frame_done_count", 64'(done2_cnt),     64'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
